// File: rtl/led_status_coder.sv
// Status LED coder: blink-code fault report, link-down heartbeat mirror, link-up steady-on.
// o_led updates one clock after each heart-beat edge (tick); no backpressure, inputs sampled on ticks only.
module led_status_coder #(
    parameter int CODE_WIDTH = 4,
    parameter int GAP_TICKS  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_heart_beat,
    input  logic                  i_link_up,
    input  logic [CODE_WIDTH-1:0] i_err_code,
    output logic                  o_led,
    output logic                  o_busy,
    output logic [CODE_WIDTH-1:0] o_code
);

    typedef enum logic [2:0] {
        S_DOWN,
        S_UP,
        S_ERR_ON,
        S_ERR_OFF,
        S_ERR_GAP
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP_TICKS - 1);

    state_t                state;
    state_t                state_nxt;
    logic                  hb_q;
    logic                  tick;
    logic                  apply_d;
    logic                  led_nxt;
    logic                  busy_nxt;
    logic [CODE_WIDTH-1:0] code_nxt;
    logic [CODE_WIDTH-1:0] pulse_cnt;
    logic [CODE_WIDTH-1:0] pulse_nxt;
    logic [7:0]            gap_cnt;
    logic [7:0]            gap_nxt;

    // Either heart-beat edge is one time-base tick.
    assign tick = i_heart_beat ^ hb_q;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            hb_q      <= 1'b0;
            state     <= S_DOWN;
            o_led     <= 1'b0;
            o_busy    <= 1'b0;
            o_code    <= '0;
            pulse_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            hb_q      <= i_heart_beat;
            state     <= state_nxt;
            o_led     <= led_nxt;
            o_busy    <= busy_nxt;
            o_code    <= code_nxt;
            pulse_cnt <= pulse_nxt;
            gap_cnt   <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        led_nxt   = o_led;
        code_nxt  = o_code;
        pulse_nxt = pulse_cnt;
        gap_nxt   = gap_cnt;
        apply_d   = 1'b0;

        if (tick) begin
            case (state)
                S_DOWN, S_UP: begin
                    apply_d = 1'b1;
                end
                S_ERR_ON: begin
                    led_nxt   = 1'b0;
                    state_nxt = S_ERR_OFF;
                    if (pulse_cnt != '0) begin
                        pulse_nxt = pulse_cnt - CODE_WIDTH'(1);
                    end
                end
                S_ERR_OFF: begin
                    if (pulse_cnt != '0) begin
                        led_nxt   = 1'b1;
                        state_nxt = S_ERR_ON;
                    end else begin
                        gap_nxt   = GAP_LOAD;
                        state_nxt = S_ERR_GAP;
                    end
                end
                S_ERR_GAP: begin
                    if (gap_cnt != 8'd0) begin
                        gap_nxt = gap_cnt - 8'd1;
                    end else begin
                        apply_d = 1'b1;
                    end
                end
                default: begin
                    led_nxt   = 1'b0;
                    state_nxt = S_DOWN;
                end
            endcase
        end

        // Decision point: a fresh code is latched only here, so a frame always completes as started.
        if (apply_d) begin
            if (i_err_code != '0) begin
                code_nxt  = i_err_code;
                pulse_nxt = i_err_code;
                led_nxt   = 1'b1;
                state_nxt = S_ERR_ON;
            end else if (i_link_up) begin
                led_nxt   = 1'b1;
                state_nxt = S_UP;
            end else begin
                led_nxt   = i_heart_beat;
                state_nxt = S_DOWN;
            end
        end

        busy_nxt = (state_nxt == S_ERR_ON) || (state_nxt == S_ERR_OFF) ||
                   (state_nxt == S_ERR_GAP);
    end

endmodule

// File: tb/tb_led_status_coder.sv
// Randomized bench for led_status_coder against a tick-level frame-plan reference model.
module tb_led_status_coder;

    localparam int CW  = 4;
    localparam int GAP = 4;

    logic          clk   = 1'b0;
    logic          run   = 1'b0;
    logic          rst_n = 1'b1;
    logic          hb    = 1'b0;
    logic          link  = 1'b0;
    logic [CW-1:0] err   = '0;
    logic          led;
    logic          busy;
    logic [CW-1:0] code;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: on each tick either pop the next planned LED value of a running
    // frame, or make a fresh decision which may lay out a whole new frame.
    bit            m_hbq;
    bit            m_led;
    bit            m_busy;
    logic [CW-1:0] m_code;
    bit            plan[$];

    led_status_coder #(.CODE_WIDTH(CW), .GAP_TICKS(GAP)) dut (
        .i_clk       (clk),
        .i_arst_n    (rst_n),
        .i_heart_beat(hb),
        .i_link_up   (link),
        .i_err_code  (err),
        .o_led       (led),
        .o_busy      (busy),
        .o_code      (code)
    );

    always begin
        #5;
        if (run) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hbq  = 1'b0;
        m_led  = 1'b0;
        m_busy = 1'b0;
        m_code = '0;
        plan.delete();
    endtask

    task automatic model_step();
        if (hb != m_hbq) begin
            if (plan.size() != 0) begin
                m_led  = plan.pop_front();
                m_busy = 1'b1;
            end else if (err != '0) begin
                m_code = err;
                m_busy = 1'b1;
                m_led  = 1'b1;
                for (int p = 0; p < int'(err); p++) begin
                    if (p > 0) plan.push_back(1'b1);
                    plan.push_back(1'b0);
                end
                repeat (GAP) plan.push_back(1'b0);
            end else begin
                m_busy = 1'b0;
                m_led  = link ? 1'b1 : hb;
            end
        end
        m_hbq = hb;
    endtask

    task automatic clk1();
        @(posedge clk);
        model_step();
        #1;
        chk("led", 32'(led), 32'(m_led));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("code", 32'(code), 32'(m_code));
    endtask

    task automatic do_tick(input int hold);
        hb = ~hb;
        clk1();
        repeat (hold) clk1();
    endtask

    bit exp3 [10];

    initial begin
        exp3 = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0};
        model_reset();

        // Reset with the clock stopped
        #2 rst_n = 1'b0;
        #2;
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_code", 32'(code), 32'd0);
        run = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) clk1();
        chk("idle_led", 32'(led), 32'd0);

        // Link-down mirror
        repeat (10) do_tick(7);

        // Link up mid-period, then drop it
        hb = ~hb;
        repeat (4) clk1();
        link = 1'b1;
        repeat (4) clk1();
        repeat (10) do_tick(7);
        chk("up_led", 32'(led), 32'd1);
        link = 1'b0;
        repeat (4) clk1();
        repeat (4) do_tick(7);

        // Code 3 frame, then clear with link up
        err = 4'd3;
        for (int i = 0; i < 10; i++) begin
            hb = ~hb;
            clk1();
            chk("frame3_led", 32'(led), 32'(exp3[i]));
            chk("frame3_busy", 32'(busy), 32'd1);
            chk("frame3_code", 32'(code), 32'd3);
            repeat (2) clk1();
        end
        err  = 4'd0;
        link = 1'b1;
        do_tick(2);
        chk("clear_led", 32'(led), 32'd1);
        chk("clear_busy", 32'(busy), 32'd0);

        // Code change mid-frame, then error cleared mid-frame
        link = 1'b0;
        err  = 4'd3;
        repeat (4) do_tick(1);
        err = 4'd5;
        repeat (30) do_tick(1);
        chk("chg_code", 32'(code), 32'd5);
        err = 4'd0;
        repeat (25) do_tick(1);

        // Async reset while in an on-pulse
        for (int k = 0; k < 60 && m_busy; k++) do_tick(0);
        err = 4'd2;
        do_tick(0);
        chk("pre_rst_led", 32'(led), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_led", 32'(led), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_code", 32'(code), 32'd0);
        model_reset();
        #3 rst_n = 1'b1;
        repeat (20) do_tick($urandom_range(0, 2));

        // Random traffic
        repeat (500) begin
            if ($urandom_range(0, 7) == 0) link = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 5) == 0)
                err = ($urandom_range(0, 2) == 0) ? CW'($urandom_range(1, 15)) : '0;
            if ($urandom_range(0, 9) == 0) clk1();
            else do_tick($urandom_range(0, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
